muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the MiniSys pipeline's execute stage. It takes MULT/MULTU/DIV/DIVU operands from EX and holds the pipeline with a stall request while a 32-step shift-add or restoring-divide loop runs. It writes the 64-bit result into the architectural HI/LO registers and also handles MTHI/MTLO writes. It is the only writer of HI/LO.

---
 rtl/muldiv_seq.sv | 171 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative 32x32 multiply / 32/32 divide sequencer that owns the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with sign fix-up at the end.
module muldiv_seq (
   input  logic        clk,
   input  logic        clrn,
   input  logic        startE,
   input  logic [1:0]  opE,
   input  logic [31:0] rd1E,
   input  logic [31:0] rd2E,
   input  logic [1:0]  mtE,
   input  logic        flushE,
   output logic        stallE,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StFix  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        div_q, div_d;
   logic        sgn_q, sgn_d;
   logic        rsgn_q, rsgn_d;
   logic        dz_q, dz_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [31:0] abs1, abs2;
   logic        accept;
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [32:0] r_sh;
   logic [32:0] diff;
   logic        qbit;
   logic [31:0] rem_next;
   logic [63:0] div_next;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign accept = startE & ~flushE;
   assign abs1   = (opE[0] & rd1E[31]) ? -rd1E : rd1E;
   assign abs2   = (opE[0] & rd2E[31]) ? -rd2E : rd2E;

   // Multiply: upper half accumulates, whole accumulator shifts right one bit per step.
   assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
   assign mul_next = {mul_sum, acc_q[31:1]};

   // Divide: acc[63:32] is the partial remainder, acc[31:0] collects quotient bits.
   assign r_sh     = {acc_q[63:32], a_q[31]};
   assign diff     = r_sh - {1'b0, b_q};
   assign qbit     = ~diff[32];
   assign rem_next = qbit ? diff[31:0] : r_sh[31:0];
   assign div_next = {rem_next, acc_q[30:0], qbit};

   assign prod_fix = sgn_q  ? -acc_q         : acc_q;
   assign quo_fix  = sgn_q  ? -acc_q[31:0]   : acc_q[31:0];
   assign rem_fix  = rsgn_q ? -acc_q[63:32]  : acc_q[63:32];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      div_d   = div_q;
      sgn_d   = sgn_q;
      rsgn_d  = rsgn_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               a_d    = abs1;
               b_d    = abs2;
               div_d  = opE[1];
               sgn_d  = opE[0] & (rd1E[31] ^ rd2E[31]);
               rsgn_d = opE[0] & rd1E[31];
               acc_d  = 64'd0;
               cnt_d  = 5'd0;
               if (opE[1] && (rd2E == 32'd0)) begin
                  dz_d    = 1'b1;
                  state_d = StDone;
               end else begin
                  dz_d    = 1'b0;
                  state_d = StRun;
               end
            end else if (!startE) begin
               if (mtE[1]) hi_d = rd1E;
               if (mtE[0]) lo_d = rd1E;
            end
         end
         StRun: begin
            if (flushE) begin
               state_d = StIdle;
            end else begin
               if (div_q) begin
                  acc_d = div_next;
                  a_d   = {a_q[30:0], 1'b0};
               end else begin
                  acc_d = mul_next;
                  b_d   = {1'b0, b_q[31:1]};
               end
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_d = StFix;
            end
         end
         StFix: begin
            if (flushE) begin
               state_d = StIdle;
            end else begin
               if (div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[63:32];
                  lo_d = prod_fix[31:0];
               end
               state_d = StDone;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= StIdle;
         cnt_q   <= 5'd0;
         acc_q   <= 64'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         div_q   <= 1'b0;
         sgn_q   <= 1'b0;
         rsgn_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         div_q   <= div_d;
         sgn_q   <= sgn_d;
         rsgn_q  <= rsgn_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign stallE   = ((state_q == StIdle) & accept) | (state_q == StRun) | (state_q == StFix);
   assign done     = (state_q == StDone);
   assign div_zero = (state_q == StDone) & dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: fixed vectors, hand-written corner sequences and
// random operations compared against a plain-arithmetic model of HI/LO.
module tb_muldiv_seq;

   logic        clk;
   logic        clrn;
   logic        startE;
   logic [1:0]  opE;
   logic [31:0] rd1E;
   logic [31:0] rd2E;
   logic [1:0]  mtE;
   logic        flushE;
   logic        stallE;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] m_hi, m_lo;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   vec_t tbl[5];

   muldiv_seq dut (
      .clk      (clk),
      .clrn     (clrn),
      .startE   (startE),
      .opE      (opE),
      .rd1E     (rd1E),
      .rd2E     (rd2E),
      .mtE      (mtE),
      .flushE   (flushE),
      .stallE   (stallE),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: architectural result from ordinary integer arithmetic.
   task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] eh, output logic [31:0] el, output logic edz);
      longint sa, sb, sp;
      logic [63:0] up;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      edz = 1'b0;
      eh  = m_hi;
      el  = m_lo;
      case (op)
         2'b00: begin
            up = {32'd0, a} * {32'd0, b};
            eh = up[63:32];
            el = up[31:0];
         end
         2'b01: begin
            sp = sa * sb;
            up = sp;
            eh = up[63:32];
            el = up[31:0];
         end
         2'b10: begin
            if (b == 32'd0) edz = 1'b1;
            else begin
               el = a / b;
               eh = a % b;
            end
         end
         default: begin
            if (b == 32'd0) edz = 1'b1;
            else begin
               sp = sa / sb;
               up = sp;
               el = up[31:0];
               sp = sa % sb;
               up = sp;
               eh = up[31:0];
            end
         end
      endcase
   endtask

   // Issues one op at T0 and holds startE until the done cycle, as a stalled EX would.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] mt, input logic [31:0] eh, input logic [31:0] el,
                         input logic edz);
      int cyc;
      int stalls;
      bit seen;
      @(negedge clk);
      startE = 1'b1;
      opE    = op;
      rd1E   = a;
      rd2E   = b;
      mtE    = mt;
      flushE = 1'b0;
      #1;
      stalls = stallE ? 1 : 0;
      cyc    = 0;
      seen   = 0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         #1;
         cyc++;
         if (done) seen = 1;
         else if (stallE) stalls++;
      end
      chk("latency", 64'(cyc), edz ? 64'd1 : 64'd34);
      chk("stall_cycles", 64'(stalls), edz ? 64'd1 : 64'd34);
      chk("stall_in_done", {63'd0, stallE}, 64'd0);
      chk("div_zero", {63'd0, div_zero}, {63'd0, edz});
      chk("hi", {32'd0, hi}, {32'd0, eh});
      chk("lo", {32'd0, lo}, {32'd0, el});
      @(negedge clk);
      startE = 1'b0;
      mtE    = 2'b00;
      #1;
      chk("single_done", {63'd0, done}, 64'd0);
      chk("idle_stall", {63'd0, stallE}, 64'd0);
      m_hi = eh;
      m_lo = el;
   endtask

   task automatic mt_write(input logic [1:0] mt, input logic [31:0] val);
      @(negedge clk);
      startE = 1'b0;
      mtE    = mt;
      rd1E   = val;
      #1;
      chk("mt_no_stall", {63'd0, stallE}, 64'd0);
      if (mt[1]) m_hi = val;
      if (mt[0]) m_lo = val;
      @(negedge clk);
      mtE = 2'b00;
      #1;
      chk("mt_hi", {32'd0, hi}, {32'd0, m_hi});
      chk("mt_lo", {32'd0, lo}, {32'd0, m_lo});
   endtask

   // Starts an op and raises flushE n cycles after acceptance.
   task automatic start_flush(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input int n);
      @(negedge clk);
      startE = 1'b1;
      opE    = op;
      rd1E   = a;
      rd2E   = b;
      mtE    = 2'b00;
      flushE = 1'b0;
      repeat (n) @(negedge clk);
      flushE = 1'b1;
      #1;
      chk("flush_cycle_stall", {63'd0, stallE}, 64'd1);
   endtask

   initial begin
      logic [31:0] eh, el;
      logic        edz;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int          ndone;

      tbl[0] = '{op: 2'b01, a: 32'hFFFFFFFD, b: 32'h00000007, eh: 32'hFFFFFFFF, el: 32'hFFFFFFEB};
      tbl[1] = '{op: 2'b00, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, eh: 32'hFFFFFFFE, el: 32'h00000001};
      tbl[2] = '{op: 2'b11, a: 32'hFFFFFFF9, b: 32'h00000002, eh: 32'hFFFFFFFF, el: 32'hFFFFFFFD};
      tbl[3] = '{op: 2'b10, a: 32'd100,      b: 32'd7,        eh: 32'd2,        el: 32'd14};
      tbl[4] = '{op: 2'b11, a: 32'h80000000, b: 32'hFFFFFFFF, eh: 32'h00000000, el: 32'h80000000};

      clrn   = 1'b0;
      startE = 1'b0;
      opE    = 2'b00;
      rd1E   = 32'd0;
      rd2E   = 32'd0;
      mtE    = 2'b00;
      flushE = 1'b0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      #1;
      chk("reset_hi", {32'd0, hi}, 64'd0);
      chk("reset_lo", {32'd0, lo}, 64'd0);
      chk("reset_stall", {63'd0, stallE}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);

      for (int i = 0; i < 5; i++)
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, 2'b00, tbl[i].eh, tbl[i].el, 1'b0);

      // Divide by zero leaves preloaded HI/LO untouched.
      mt_write(2'b11, 32'h11);
      mt_write(2'b01, 32'h22);
      run_op(2'b10, 32'd5, 32'd0, 2'b00, 32'h11, 32'h22, 1'b1);
      run_op(2'b11, 32'h80000000, 32'd0, 2'b00, 32'h11, 32'h22, 1'b1);

      // Flush in RUN, then idle long enough that a leaked result would have landed.
      start_flush(2'b01, 32'h12345678, 32'h9ABCDEF0, 10);
      @(negedge clk);
      startE = 1'b0;
      flushE = 1'b0;
      ndone  = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         if (done) ndone++;
      end
      chk("flush_no_done", 64'(ndone), 64'd0);
      chk("flush_hi", {32'd0, hi}, {32'd0, m_hi});
      chk("flush_lo", {32'd0, lo}, {32'd0, m_lo});

      // Flush at T10, new instruction accepted at T11.
      start_flush(2'b00, 32'hDEADBEEF, 32'h3, 10);
      model(2'b10, 32'd1000, 32'd33, eh, el, edz);
      run_op(2'b10, 32'd1000, 32'd33, 2'b00, eh, el, edz);

      // startE wins over mtE in the same IDLE cycle.
      model(2'b00, 32'd6, 32'd7, eh, el, edz);
      run_op(2'b00, 32'd6, 32'd7, 2'b11, eh, el, edz);

      for (int i = 0; i < 24; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if (i % 6 == 5) rb = 32'($urandom_range(1, 15));
         model(rop, ra, rb, eh, el, edz);
         run_op(rop, ra, rb, 2'b00, eh, el, edz);
      end

      // Asynchronous reset partway through a divide.
      @(negedge clk);
      startE = 1'b1;
      opE    = 2'b11;
      rd1E   = 32'h7FFFFFFF;
      rd2E   = 32'd3;
      repeat (20) @(negedge clk);
      startE = 1'b0;
      clrn   = 1'b0;
      #1;
      chk("midreset_hi", {32'd0, hi}, 64'd0);
      chk("midreset_lo", {32'd0, lo}, 64'd0);
      chk("midreset_stall", {63'd0, stallE}, 64'd0);
      chk("midreset_done", {63'd0, done}, 64'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      clrn = 1'b1;
      model(2'b01, 32'hFFFFFFFF, 32'h80000000, eh, el, edz);
      run_op(2'b01, 32'hFFFFFFFF, 32'h80000000, 2'b00, eh, el, edz);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
